// File: rtl/sal_bk_pkg.sv
// Shared types and helpers for the SAL per-bank controller (sal_bk_ctrl_q)
// and its request FIFO.
package sal_bk_pkg;

    // Entry field widths; the controller's RA_W/CA_W/ID_W must match these.
    localparam int BK_RA_W = 16;
    localparam int BK_CA_W = 10;
    localparam int BK_ID_W = 8;

    typedef enum logic [1:0] {
        BK_IDLE        = 2'd0,
        BK_ACTIVATING  = 2'd1,
        BK_ACTIVE      = 2'd2,
        BK_PRECHARGING = 2'd3
    } bk_state_t;

    typedef struct packed {
        logic               wr;
        logic [BK_RA_W-1:0] ra;
        logic [BK_CA_W-1:0] ca;
        logic [BK_ID_W-1:0] id;
    } bk_entry_t;

    // Counters hold t-1 after the grant so the dependent command is legal t cycles later.
    function automatic int unsigned tim_load(input int unsigned t);
        return (t == 0) ? 0 : t - 1;
    endfunction

endpackage

// File: rtl/sal_bk_req_fifo.sv
// In-order request buffer for one bank; head is the oldest entry.
// Push while full is accepted only when a pop happens in the same cycle.
module sal_bk_req_fifo
    import sal_bk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  bk_entry_t din,
    output logic      full,
    output logic      empty,
    output bk_entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    bk_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_en;
    logic          pop_en;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_en) - CW'(pop_en);
        end
    end

endmodule

// File: rtl/sal_bk_ctrl_q.sv
// SAL per-bank controller: request buffering, open-row tracking, tRCD/tRAS/tRP/tRTP/tWTP
// gating and refresh arbitration. Define SAL_BK_PAGE_TIMEOUT_EN for idle page auto-close.
module sal_bk_ctrl_q
    import sal_bk_pkg::*;
#(
    parameter int BK_ID        = 0,
    parameter int BA_W         = 4,
    parameter int RA_W         = 16,
    parameter int CA_W         = 10,
    parameter int ID_W         = 8,
    parameter int TW           = 8,
    parameter int REQ_DEPTH    = 4,
    parameter int PAGE_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [TW-1:0]   t_rcd_i,
    input  logic [TW-1:0]   t_ras_i,
    input  logic [TW-1:0]   t_rp_i,
    input  logic [TW-1:0]   t_rtp_i,
    input  logic [TW-1:0]   t_wtp_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_wr_i,
    input  logic [RA_W-1:0] req_ra_i,
    input  logic [CA_W-1:0] req_ca_i,
    input  logic [ID_W-1:0] req_id_i,
    output logic            act_req_o,
    output logic            rd_req_o,
    output logic            wr_req_o,
    output logic            pre_req_o,
    input  logic            act_gnt_i,
    input  logic            rd_gnt_i,
    input  logic            wr_gnt_i,
    input  logic            pre_gnt_i,
    output logic [BA_W-1:0] bk_ba_o,
    output logic [RA_W-1:0] bk_ra_o,
    output logic [CA_W-1:0] bk_ca_o,
    output logic [ID_W-1:0] bk_id_o,
    input  logic            ref_req_i,
    output logic            ref_gnt_o
);

    bk_state_t       state;
    bk_entry_t       req_entry;
    bk_entry_t       head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [RA_W-1:0] open_row;
    logic [TW-1:0]   cnt_rcd;
    logic [TW-1:0]   cnt_ras;
    logic [TW-1:0]   cnt_rp;
    logic [TW-1:0]   cnt_rtp;
    logic [TW-1:0]   cnt_wtp;
    logic            eff_idle;
    logic            eff_active;
    logic            head_hit;
    logic            pre_ok;
    logic            close_want;
    logic            timeout;
    logic            act_fire;
    logic            rd_fire;
    logic            wr_fire;
    logic            pre_fire;

    function automatic logic [TW-1:0] cnt_next(input logic [TW-1:0] cur, input logic ld,
                                               input logic [TW-1:0] t);
        if (ld) begin
            return TW'(tim_load(32'(t)));
        end
        return (cur == '0) ? '0 : cur - TW'(1);
    endfunction

    assign req_entry.wr = req_wr_i;
    assign req_entry.ra = req_ra_i;
    assign req_entry.ca = req_ca_i;
    assign req_entry.id = req_id_i;

    sal_bk_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (req_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // The wait states hand over in the same cycle their counter reaches zero,
    // so the follow-on command is offered exactly t cycles after the grant.
    assign eff_idle   = (state == BK_IDLE) | ((state == BK_PRECHARGING) & (cnt_rp == '0));
    assign eff_active = (state == BK_ACTIVE) | ((state == BK_ACTIVATING) & (cnt_rcd == '0));
    assign head_hit   = ~fifo_empty & (head.ra == open_row);
    assign pre_ok     = (cnt_ras == '0) & (cnt_rtp == '0) & (cnt_wtp == '0);
    assign close_want = (~fifo_empty & ~head_hit) | ref_req_i | timeout;

    assign act_req_o = eff_idle & ~fifo_empty & ~ref_req_i & (cnt_rp == '0);
    assign rd_req_o  = eff_active & head_hit & ~ref_req_i & ~head.wr;
    assign wr_req_o  = eff_active & head_hit & ~ref_req_i & head.wr;
    assign pre_req_o = eff_active & close_want & pre_ok;
    assign ref_gnt_o = rst_n & ref_req_i & eff_idle & (cnt_rp == '0);

    // Grants without a matching request are dropped here.
    assign act_fire = act_gnt_i & act_req_o;
    assign rd_fire  = rd_gnt_i & rd_req_o;
    assign wr_fire  = wr_gnt_i & wr_req_o;
    assign pre_fire = pre_gnt_i & pre_req_o;

    assign pop         = rd_fire | wr_fire;
    assign req_ready_o = ~fifo_full | pop;
    assign push        = req_valid_i & req_ready_o;

    assign bk_ba_o = BA_W'(BK_ID);
    assign bk_ra_o = head.ra;
    assign bk_ca_o = head.ca;
    assign bk_id_o = head.id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BK_IDLE;
            open_row <= '0;
            cnt_rcd  <= '0;
            cnt_ras  <= '0;
            cnt_rp   <= '0;
            cnt_rtp  <= '0;
            cnt_wtp  <= '0;
        end else begin
            cnt_rcd <= cnt_next(cnt_rcd, act_fire, t_rcd_i);
            cnt_ras <= cnt_next(cnt_ras, act_fire, t_ras_i);
            cnt_rp  <= cnt_next(cnt_rp, pre_fire, t_rp_i);
            cnt_rtp <= cnt_next(cnt_rtp, rd_fire, t_rtp_i);
            cnt_wtp <= cnt_next(cnt_wtp, wr_fire, t_wtp_i);
            if (act_fire) begin
                open_row <= head.ra;
            end
            case (state)
                BK_IDLE: begin
                    if (act_fire) state <= BK_ACTIVATING;
                end
                BK_ACTIVATING: begin
                    if (pre_fire) state <= BK_PRECHARGING;
                    else if (cnt_rcd == '0) state <= BK_ACTIVE;
                end
                BK_ACTIVE: begin
                    if (pre_fire) state <= BK_PRECHARGING;
                end
                BK_PRECHARGING: begin
                    if (act_fire) state <= BK_ACTIVATING;
                    else if (cnt_rp == '0) state <= BK_IDLE;
                end
                default: state <= BK_IDLE;
            endcase
        end
    end

`ifdef SAL_BK_PAGE_TIMEOUT_EN
    localparam int IW = $clog2(PAGE_TIMEOUT + 1);

    logic [IW-1:0] idle_cnt;
    logic          any_fire;

    assign any_fire = act_fire | rd_fire | wr_fire | pre_fire;
    assign timeout  = eff_active & fifo_empty & (idle_cnt == IW'(PAGE_TIMEOUT));

    // Counts consecutive open-and-idle cycles, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (push | any_fire | ~eff_active | ~fifo_empty) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IW'(PAGE_TIMEOUT)) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end
`else
    logic unused_page_cfg;

    assign timeout         = 1'b0;
    assign unused_page_cfg = (PAGE_TIMEOUT < 0);
`endif

`ifndef SYNTHESIS
    a_act_gnt: assert property (@(posedge clk) disable iff (!rst_n) act_gnt_i |-> act_req_o)
        else $error("sal_bk_ctrl_q: act_gnt_i without act_req_o");
    a_rd_gnt: assert property (@(posedge clk) disable iff (!rst_n) rd_gnt_i |-> rd_req_o)
        else $error("sal_bk_ctrl_q: rd_gnt_i without rd_req_o");
    a_wr_gnt: assert property (@(posedge clk) disable iff (!rst_n) wr_gnt_i |-> wr_req_o)
        else $error("sal_bk_ctrl_q: wr_gnt_i without wr_req_o");
    a_pre_gnt: assert property (@(posedge clk) disable iff (!rst_n) pre_gnt_i |-> pre_req_o)
        else $error("sal_bk_ctrl_q: pre_gnt_i without pre_req_o");
    a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n)
                                $onehot0({act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i}))
        else $error("sal_bk_ctrl_q: more than one grant in a cycle");
`endif

endmodule

// File: tb/tb_sal_bk_ctrl_q.sv
// Randomized bench for sal_bk_ctrl_q against a timestamp-based bank model.
// Honours SAL_BK_PAGE_TIMEOUT_EN when the design is built with it.
module tb_sal_bk_ctrl_q;

    localparam int DEPTH = 4;
    localparam int PTO   = 16;
    localparam int BKID  = 5;

    typedef struct {
        logic        wr;
        logic [15:0] ra;
        logic [9:0]  ca;
        logic [7:0]  id;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  t_rcd, t_ras, t_rp, t_rtp, t_wtp;
    logic        req_valid, req_ready, req_wr;
    logic [15:0] req_ra;
    logic [9:0]  req_ca;
    logic [7:0]  req_id;
    logic        act_req, rd_req, wr_req, pre_req;
    logic        act_gnt, rd_gnt, wr_gnt, pre_gnt;
    logic [3:0]  bk_ba;
    logic [15:0] bk_ra;
    logic [9:0]  bk_ca;
    logic [7:0]  bk_id;
    logic        ref_req, ref_gnt;

    int total, bad, cyc;

    // Reference model: queue of pending requests plus the cycle of the last grant of each kind.
    ent_t        q[$];
    bit          m_open;
    logic [15:0] m_row;
    int          act_t, pre_t, rd_t, wr_t, m_idle;
    bit          p_act, p_rd, p_wr, p_pre, p_push;
    ent_t        p_ent;
    int          p_idle;
    bit          e_act, e_rd, e_wr, e_pre, e_rgnt, e_ready;

    int          ts [3][5] = '{'{3, 8, 4, 2, 5}, '{1, 1, 1, 1, 1}, '{2, 6, 3, 4, 6}};
    logic [15:0] ra_tab [4] = '{16'h0012, 16'h0034, 16'h0056, 16'h0012};

    sal_bk_ctrl_q #(
        .BK_ID(BKID), .BA_W(4), .RA_W(16), .CA_W(10), .ID_W(8), .TW(8),
        .REQ_DEPTH(DEPTH), .PAGE_TIMEOUT(PTO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .t_rcd_i(t_rcd), .t_ras_i(t_ras), .t_rp_i(t_rp), .t_rtp_i(t_rtp), .t_wtp_i(t_wtp),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
        .req_ra_i(req_ra), .req_ca_i(req_ca), .req_id_i(req_id),
        .act_req_o(act_req), .rd_req_o(rd_req), .wr_req_o(wr_req), .pre_req_o(pre_req),
        .act_gnt_i(act_gnt), .rd_gnt_i(rd_gnt), .wr_gnt_i(wr_gnt), .pre_gnt_i(pre_gnt),
        .bk_ba_o(bk_ba), .bk_ra_o(bk_ra), .bk_ca_o(bk_ca), .bk_id_o(bk_id),
        .ref_req_i(ref_req), .ref_gnt_o(ref_gnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_open = 0; m_row = '0; m_idle = 0;
        act_t = -1000; pre_t = -1000; rd_t = -1000; wr_t = -1000;
        p_act = 0; p_rd = 0; p_wr = 0; p_pre = 0; p_push = 0; p_idle = 0;
    endtask

    task automatic model_apply();
        if (p_act) begin m_open = 1; m_row = q[0].ra; act_t = cyc - 1; end
        if (p_pre) begin m_open = 0; pre_t = cyc - 1; end
        if (p_rd || p_wr) begin
            void'(q.pop_front());
            if (p_rd) rd_t = cyc - 1;
            else      wr_t = cyc - 1;
        end
        if (p_push) q.push_back(p_ent);
        m_idle = p_idle;
    endtask

    task automatic compute_exp();
        bit active_ok, closed_ok, hit, close, tmo;
        active_ok = m_open && (cyc >= act_t + int'(t_rcd));
        closed_ok = !m_open && (cyc >= pre_t + int'(t_rp));
        hit       = (q.size() > 0) && (q[0].ra == m_row);
        tmo       = 0;
`ifdef SAL_BK_PAGE_TIMEOUT_EN
        tmo       = (q.size() == 0) && (m_idle >= PTO);
`endif
        close  = ((q.size() > 0) && !hit) || ref_req || tmo;
        e_act  = closed_ok && (q.size() > 0) && !ref_req;
        e_rd   = active_ok && hit && !ref_req && !q[0].wr;
        e_wr   = active_ok && hit && !ref_req && q[0].wr;
        e_pre  = active_ok && close && (cyc >= act_t + int'(t_ras)) &&
                 (cyc >= rd_t + int'(t_rtp)) && (cyc >= wr_t + int'(t_wtp));
        e_rgnt = ref_req && closed_ok;
    endtask

    task automatic chk_reset();
        check("rst_act", 32'(act_req), 32'd0);
        check("rst_rd", 32'(rd_req), 32'd0);
        check("rst_wr", 32'(wr_req), 32'd0);
        check("rst_pre", 32'(pre_req), 32'd0);
        check("rst_refg", 32'(ref_gnt), 32'd0);
        check("rst_rdy", 32'(req_ready), 32'd1);
    endtask

    task automatic set_timing(input int s);
        t_rcd = 8'(ts[s][0]); t_ras = 8'(ts[s][1]); t_rp = 8'(ts[s][2]);
        t_rtp = 8'(ts[s][3]); t_wtp = 8'(ts[s][4]);
    endtask

    task automatic run(input int n, input int vld_pct, input int gnt_pct, input int ref_pct);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            model_apply();
            #1;
            if (ref_pct == 0) ref_req = 1'b0;
            else if (ref_req) begin
                if ($urandom_range(99) < 8) ref_req = 1'b0;
            end else if ($urandom_range(999) < ref_pct) ref_req = 1'b1;
            req_valid = ($urandom_range(99) < vld_pct);
            req_wr    = 1'($urandom_range(1));
            req_ra    = ra_tab[$urandom_range(3)];
            req_ca    = 10'($urandom);
            req_id    = 8'($urandom);
            compute_exp();
            act_gnt = 0; rd_gnt = 0; wr_gnt = 0; pre_gnt = 0;
            if ($urandom_range(99) < gnt_pct) begin
                act_gnt = e_act; rd_gnt = e_rd; wr_gnt = e_wr; pre_gnt = e_pre;
            end
            e_ready  = (q.size() < DEPTH) || rd_gnt || wr_gnt;
            p_act    = act_gnt; p_rd = rd_gnt; p_wr = wr_gnt; p_pre = pre_gnt;
            p_push   = req_valid && e_ready;
            p_ent.wr = req_wr; p_ent.ra = req_ra; p_ent.ca = req_ca; p_ent.id = req_id;
            if (m_open && (cyc >= act_t + int'(t_rcd)) && (q.size() == 0) && !p_push &&
                !(act_gnt || rd_gnt || wr_gnt || pre_gnt))
                p_idle = (m_idle + 1 > PTO) ? PTO : m_idle + 1;
            else
                p_idle = 0;
            @(negedge clk);
            check("act_req", 32'(act_req), 32'(e_act));
            check("rd_req", 32'(rd_req), 32'(e_rd));
            check("wr_req", 32'(wr_req), 32'(e_wr));
            check("pre_req", 32'(pre_req), 32'(e_pre));
            check("ref_gnt", 32'(ref_gnt), 32'(e_rgnt));
            check("ready", 32'(req_ready), 32'(e_ready));
            if (q.size() > 0) begin
                check("head_ra", 32'(bk_ra), 32'(q[0].ra));
                check("head_ca", 32'(bk_ca), 32'(q[0].ca));
                check("head_id", 32'(bk_id), 32'(q[0].id));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst_n = 1'b0; ref_req = 1'b1; req_valid = 1'b1;
        req_wr = 0; req_ra = '0; req_ca = '0; req_id = '0;
        act_gnt = 0; rd_gnt = 0; wr_gnt = 0; pre_gnt = 0;
        set_timing(0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_reset();
        @(negedge clk);
        ref_req = 1'b0; req_valid = 1'b0; rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) begin
                // Asynchronous reset in the middle of traffic.
                @(posedge clk);
                #3;
                rst_n = 1'b0; ref_req = 1'b1; req_valid = 1'b1;
                act_gnt = 0; rd_gnt = 0; wr_gnt = 0; pre_gnt = 0;
                set_timing(s);
                #1 chk_reset();
                model_reset();
                @(posedge clk);
                @(negedge clk);
                ref_req = 1'b0; req_valid = 1'b0; rst_n = 1'b1;
            end
            run(600, 40, 60, 10);
            run(60, 90, 0, 0);
            run(300, 30, 80, 0);
            run(200, 0, 80, 0);
            run(300, 50, 50, 30);
        end
        check("bk_ba", 32'(bk_ba), 32'(BKID));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
